sar_logic: RTL

// Synchronous successive-approximation controller; the digital counterpart of the clocked comparator (comp).

---
 rtl/sar_logic_pkg.sv | 27 ++
 rtl/sync_2ff.sv | 32 +++
 rtl/sar_logic.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sar_logic_pkg.sv
// Shared types and defaults for the successive-approximation controller.
// The FSM state encoding and counter sizing live here so that benches and top agree.
package sar_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SAMPLE,
      COMP,
      RESET,
      DONE
   } sar_state_t;

   localparam int DEF_RESOLUTION    = 8;
   localparam int DEF_SAMPLE_CYCLES = 2;
   localparam int DEF_COMP_TIMEOUT  = 7;

   // Depth of the comparator synchronizer; its output is stale for this many cycles.
   localparam int SYNC_STAGES = 2;

   // One counter serves both the sample window and the comparator waits.
   function automatic int cnt_width(input int timeout, input int sample_cycles);
      int span;
      span = (timeout > sample_cycles) ? timeout : sample_cycles;
      return (span < 1) ? 1 : $clog2(span + 1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit signals, one chain per bit.
// Each bit is synchronized independently; no multi-bit coherency is implied.
module sync_2ff #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_reg;
   logic [WIDTH-1:0] sync_reg;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               meta_reg[gi] <= 1'b0;
               sync_reg[gi] <= 1'b0;
            end else begin
               meta_reg[gi] <= d[gi];
               sync_reg[gi] <= meta_reg[gi];
            end
         end
      end
   endgenerate

   assign q = sync_reg;

endmodule

// File: rtl/sar_logic.sv
// Successive-approximation controller: samples, steps the CDAC trial code bit by bit
// from the clocked comparator decisions, and hands the final code over valid/ready.
module sar_logic
   import sar_pkg::*;
#(
   parameter int RESOLUTION    = DEF_RESOLUTION,
   parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
   parameter int COMP_TIMEOUT  = DEF_COMP_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  comp_p,
   input  logic                  comp_n,
   output logic                  sample,
   output logic                  comp_clk,
   output logic [RESOLUTION-1:0] dac_code,
   output logic                  busy,
   output logic [RESOLUTION-1:0] result,
   output logic                  result_err,
   output logic                  result_valid,
   input  logic                  result_ready
);

   localparam int CNT_W = cnt_width(COMP_TIMEOUT, SAMPLE_CYCLES);
   localparam int IDX_W = (RESOLUTION > 1) ? $clog2(RESOLUTION) : 1;

   localparam logic [CNT_W-1:0]      SAMPLE_LAST  = CNT_W'(SAMPLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]      TIMEOUT_LAST = CNT_W'(COMP_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]      SETTLE_CNT   = CNT_W'(SYNC_STAGES);
   localparam logic [IDX_W-1:0]      IDX_MSB      = IDX_W'(RESOLUTION - 1);
   localparam logic [RESOLUTION-1:0] MSB_TRIAL    = {1'b1, {(RESOLUTION-1){1'b0}}};

   sar_state_t            state_reg, state_next;
   logic [CNT_W-1:0]      cnt_reg, cnt_next;
   logic [IDX_W-1:0]      idx_reg, idx_next;
   logic [RESOLUTION-1:0] dac_code_reg, dac_code_next;
   logic                  sample_reg, sample_next;
   logic                  comp_clk_reg, comp_clk_next;
   logic                  busy_reg, busy_next;
   logic [RESOLUTION-1:0] result_reg, result_next;
   logic                  result_err_reg, result_err_next;
   logic                  result_valid_reg, result_valid_next;
   logic                  err_reg, err_next;

   logic [1:0]       comp_sync;
   logic             ps;
   logic             ns;
   logic             decided;
   logic             precharged;
   logic             settled;
   logic             at_timeout;
   logic             reset_timeout;
   logic [IDX_W-1:0] idx_dec;

   sync_2ff #(
      .WIDTH (2)
   ) u_comp_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     ({comp_p, comp_n}),
      .q     (comp_sync)
   );

   assign ps         = comp_sync[1];
   assign ns         = comp_sync[0];
   assign decided    = ps ^ ns;
   assign precharged = !ps && !ns;

   // The synchronizer still shows the previous phase for its first cycles after
   // a comp_clk edge, so decisions/precharge are only trusted once it has flushed.
   assign settled       = (cnt_reg >= SETTLE_CNT);
   assign at_timeout    = (cnt_reg == TIMEOUT_LAST);
   assign reset_timeout = at_timeout && !(settled && precharged);
   assign idx_dec       = idx_reg - IDX_W'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg        <= IDLE;
         cnt_reg          <= '0;
         idx_reg          <= '0;
         dac_code_reg     <= '0;
         sample_reg       <= 1'b0;
         comp_clk_reg     <= 1'b0;
         busy_reg         <= 1'b0;
         result_reg       <= '0;
         result_err_reg   <= 1'b0;
         result_valid_reg <= 1'b0;
         err_reg          <= 1'b0;
      end else begin
         state_reg        <= state_next;
         cnt_reg          <= cnt_next;
         idx_reg          <= idx_next;
         dac_code_reg     <= dac_code_next;
         sample_reg       <= sample_next;
         comp_clk_reg     <= comp_clk_next;
         busy_reg         <= busy_next;
         result_reg       <= result_next;
         result_err_reg   <= result_err_next;
         result_valid_reg <= result_valid_next;
         err_reg          <= err_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      cnt_next          = cnt_reg;
      idx_next          = idx_reg;
      dac_code_next     = dac_code_reg;
      sample_next       = sample_reg;
      comp_clk_next     = comp_clk_reg;
      busy_next         = busy_reg;
      result_next       = result_reg;
      result_err_next   = result_err_reg;
      result_valid_next = result_valid_reg;
      err_next          = err_reg;

      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next    = SAMPLE;
               busy_next     = 1'b1;
               sample_next   = 1'b1;
               dac_code_next = '0;
               cnt_next      = '0;
               err_next      = 1'b0;
            end
         end

         SAMPLE: begin
            if (cnt_reg == SAMPLE_LAST) begin
               state_next    = COMP;
               sample_next   = 1'b0;
               dac_code_next = MSB_TRIAL;
               comp_clk_next = 1'b1;
               idx_next      = IDX_MSB;
               cnt_next      = '0;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end

         COMP: begin
            if (settled && decided) begin
               dac_code_next[idx_reg] = ps;
               comp_clk_next          = 1'b0;
               cnt_next               = '0;
               state_next             = RESET;
            end else if (at_timeout) begin
               dac_code_next[idx_reg] = 1'b0;
               err_next               = 1'b1;
               comp_clk_next          = 1'b0;
               cnt_next               = '0;
               state_next             = RESET;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end

         RESET: begin
            if ((settled && precharged) || at_timeout) begin
               cnt_next = '0;
               err_next = err_reg | reset_timeout;
               if (idx_reg != '0) begin
                  idx_next               = idx_dec;
                  dac_code_next[idx_dec] = 1'b1;
                  comp_clk_next          = 1'b1;
                  state_next             = COMP;
               end else begin
                  result_next       = dac_code_reg;
                  result_err_next   = err_reg | reset_timeout;
                  result_valid_next = 1'b1;
                  state_next        = DONE;
               end
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end

         DONE: begin
            if (result_ready) begin
               result_valid_next = 1'b0;
               busy_next         = 1'b0;
               err_next          = 1'b0;
               state_next        = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign sample       = sample_reg;
   assign comp_clk     = comp_clk_reg;
   assign dac_code     = dac_code_reg;
   assign busy         = busy_reg;
   assign result       = result_reg;
   assign result_err   = result_err_reg;
   assign result_valid = result_valid_reg;

endmodule
